// File: rtl/delay_core_pkg.sv
// Shared definitions for the delay core: converter word width and receiver state encoding.
package delay_core_pkg;

  localparam int unsigned ADC_WIDTH = 12;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone,
    StHold
  } rx_state_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: output is combinational on the registered previous input sample.
module edge_detector (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic sig,
  output logic rise
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = en ? sig : prev_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = en & sig & ~prev_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: shifts WIDTH bits MSB-first during a cs frame, then pulses valid.
// Optional short-frame error output enabled by defining SERIAL_RX_ERR_EN.
module serial_frame_rx
  import delay_core_pkg::*;
#(
  parameter int unsigned WIDTH     = ADC_WIDTH,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cs,
  input  logic             bit_strobe,
  input  logic             sdi,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy
`ifdef SERIAL_RX_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(WIDTH);

  rx_state_t            state_q, state_d;
  logic [WIDTH-1:0]     sr_q, sr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 cs_rise;
`ifdef SERIAL_RX_ERR_EN
  logic                 err_q, err_d;
`endif

  edge_detector u_cs_edge (
    .clk  (clk),
    .nrst (nrst),
    .en   (1'b1),
    .sig  (cs),
    .rise (cs_rise)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef SERIAL_RX_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (cs_rise) begin
          state_d = StShift;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (!cs) begin
          // Reaching WIDTH leaves SHIFT, so any cs drop here is a short frame
          state_d = StIdle;
`ifdef SERIAL_RX_ERR_EN
          err_d   = 1'b1;
`endif
        end else if (bit_strobe) begin
          sr_d  = {sr_q[WIDTH-2:0], sdi};
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_d == CntFull) begin
            // Load the word now so data is visible in the same cycle valid is high
            state_d = StDone;
            data_d  = sr_d;
          end
        end
      end
      StDone: begin
        state_d = cs ? StHold : StIdle;
      end
      StHold: begin
        if (!cs) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef SERIAL_RX_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef SERIAL_RX_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign data  = data_q;
  assign valid = (state_q == StDone);
  assign busy  = (state_q == StShift);
`ifdef SERIAL_RX_ERR_EN
  assign err   = err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (WIDTH=12); err checks need SERIAL_RX_ERR_EN.
module tb_serial_frame_rx;

  logic        clk;
  logic        nrst;
  logic        cs;
  logic        bit_strobe;
  logic        sdi;
  logic [11:0] data;
  logic        valid;
  logic        busy;
`ifdef SERIAL_RX_ERR_EN
  logic        err;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [11:0] vq[$];

  serial_frame_rx #(
    .WIDTH     (12),
    .CNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .cs         (cs),
    .bit_strobe (bit_strobe),
    .sdi        (sdi),
    .data       (data),
    .valid      (valid),
    .busy       (busy)
`ifdef SERIAL_RX_ERR_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every valid pulse with its word
  always @(negedge clk) begin
    if (nrst && valid) vq.push_back(data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic edge_strobe, input logic edge_sdi);
    cs = 1'b1; bit_strobe = edge_strobe; sdi = edge_sdi;
    cyc();
    bit_strobe = 1'b0; sdi = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] word, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      repeat (gap - 1) cyc();
      bit_strobe = 1'b1;
      sdi = word[nbits-1-i];
      cyc();
      bit_strobe = 1'b0;
      sdi = 1'b0;
    end
  endtask

  task automatic end_frame(input logic fall_strobe, input logic fall_sdi);
    cs = 1'b0; bit_strobe = fall_strobe; sdi = fall_sdi;
    cyc();
    bit_strobe = 1'b0; sdi = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; cs = 1'b0; bit_strobe = 1'b0; sdi = 1'b0;
    repeat (2) cyc();
    vec_cnt++; if (data !== 12'h000) begin miss_cnt++; $display("FAIL reset_data: got %h want 000", data); end
    vec_cnt++; if (valid !== 1'b0) begin miss_cnt++; $display("FAIL reset_valid: got %b want 0", valid); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef SERIAL_RX_ERR_EN
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %b want 0", err); end
`endif
    nrst = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    int n0 = vq.size();
    start_frame(1'b0, 1'b0);
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL single_busy: got %b want 1", busy); end
    shift_bits(16'h0A5C, 12, 4);
    vec_cnt++; if (valid !== 1'b1) begin miss_cnt++; $display("FAIL single_valid: got %b want 1", valid); end
    vec_cnt++; if (data !== 12'hA5C) begin miss_cnt++; $display("FAIL single_data: got %h want a5c", data); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL single_busy_done: got %b want 0", busy); end
    cyc();
    vec_cnt++; if (valid !== 1'b0) begin miss_cnt++; $display("FAIL single_valid_width: got %b want 0", valid); end
    end_frame(1'b0, 1'b0);
    cyc();
    vec_cnt++; if (vq.size() - n0 !== 1) begin miss_cnt++; $display("FAIL single_count: got %0d want 1", vq.size() - n0); end
  endtask

  task automatic test_short();
    int n0 = vq.size();
    start_frame(1'b0, 1'b0);
    shift_bits(16'h0015, 5, 4);
    end_frame(1'b0, 1'b0);
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL short_busy: got %b want 0", busy); end
`ifdef SERIAL_RX_ERR_EN
    vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL short_err: got %b want 1", err); end
`endif
    cyc();
`ifdef SERIAL_RX_ERR_EN
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL short_err_width: got %b want 0", err); end
`endif
    vec_cnt++; if (data !== 12'hA5C) begin miss_cnt++; $display("FAIL short_data: got %h want a5c", data); end
    vec_cnt++; if (vq.size() - n0 !== 0) begin miss_cnt++; $display("FAIL short_valid: got %0d want 0", vq.size() - n0); end
  endtask

  task automatic test_overlong();
    int n0 = vq.size();
    start_frame(1'b0, 1'b0);
    shift_bits(16'h03F0, 12, 3);
    vec_cnt++; if (valid !== 1'b1) begin miss_cnt++; $display("FAIL long_valid: got %b want 1", valid); end
    vec_cnt++; if (data !== 12'h3F0) begin miss_cnt++; $display("FAIL long_data: got %h want 3f0", data); end
    shift_bits(16'h0003, 2, 3);
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL long_busy_hold: got %b want 0", busy); end
    end_frame(1'b0, 1'b0);
    cyc();
    vec_cnt++; if (data !== 12'h3F0) begin miss_cnt++; $display("FAIL long_data_kept: got %h want 3f0", data); end
    vec_cnt++; if (vq.size() - n0 !== 1) begin miss_cnt++; $display("FAIL long_count: got %0d want 1", vq.size() - n0); end
  endtask

  task automatic test_back_to_back();
    int n0 = vq.size();
    start_frame(1'b0, 1'b0);
    shift_bits(16'h0001, 12, 1);
    vec_cnt++; if (data !== 12'h001) begin miss_cnt++; $display("FAIL b2b_first: got %h want 001", data); end
    end_frame(1'b0, 1'b0);
    start_frame(1'b0, 1'b0);
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL b2b_restart: got %b want 1", busy); end
    shift_bits(16'h0FFF, 12, 1);
    vec_cnt++; if (valid !== 1'b1) begin miss_cnt++; $display("FAIL b2b_valid2: got %b want 1", valid); end
    end_frame(1'b0, 1'b0);
    cyc();
    vec_cnt++;
    if (vq.size() - n0 !== 2) begin
      miss_cnt++; $display("FAIL b2b_count: got %0d want 2", vq.size() - n0);
    end else if (vq[n0] !== 12'h001 || vq[n0+1] !== 12'hFFF) begin
      miss_cnt++; $display("FAIL b2b_order: got %h,%h want 001,fff", vq[n0], vq[n0+1]);
    end
  endtask

  task automatic test_reset_mid();
    int n0 = vq.size();
    start_frame(1'b0, 1'b0);
    shift_bits(16'h002B, 6, 2);
    nrst = 1'b0; cs = 1'b0;
    cyc();
    vec_cnt++; if (data !== 12'h000) begin miss_cnt++; $display("FAIL rmid_data: got %h want 000", data); end
    vec_cnt++; if (valid !== 1'b0) begin miss_cnt++; $display("FAIL rmid_valid: got %b want 0", valid); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL rmid_busy: got %b want 0", busy); end
`ifdef SERIAL_RX_ERR_EN
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL rmid_err: got %b want 0", err); end
`endif
    nrst = 1'b1;
    cyc();
    start_frame(1'b0, 1'b0);
    shift_bits(16'h0123, 12, 2);
    vec_cnt++; if (data !== 12'h123) begin miss_cnt++; $display("FAIL rmid_next: got %h want 123", data); end
    end_frame(1'b0, 1'b0);
    cyc();
    vec_cnt++; if (vq.size() - n0 !== 1) begin miss_cnt++; $display("FAIL rmid_count: got %0d want 1", vq.size() - n0); end
  endtask

  task automatic test_edge_strobes();
    int n0 = vq.size();
    // 11 interior bits plus a strobe on the falling edge must stay a short frame
    start_frame(1'b1, 1'b1);
    shift_bits(16'h07FF, 11, 2);
    end_frame(1'b1, 1'b1);
`ifdef SERIAL_RX_ERR_EN
    vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL edge_fall_err: got %b want 1", err); end
`endif
    cyc();
    vec_cnt++; if (vq.size() - n0 !== 0) begin miss_cnt++; $display("FAIL edge_fall_valid: got %0d want 0", vq.size() - n0); end
    vec_cnt++; if (data !== 12'h123) begin miss_cnt++; $display("FAIL edge_fall_data: got %h want 123", data); end
    start_frame(1'b1, 1'b1);
    shift_bits(16'h00F3, 12, 2);
    vec_cnt++; if (valid !== 1'b1) begin miss_cnt++; $display("FAIL edge_valid: got %b want 1", valid); end
    vec_cnt++; if (data !== 12'h0F3) begin miss_cnt++; $display("FAIL edge_data: got %h want 0f3", data); end
    end_frame(1'b1, 1'b1);
    cyc();
    vec_cnt++; if (vq.size() - n0 !== 1) begin miss_cnt++; $display("FAIL edge_count: got %0d want 1", vq.size() - n0); end
  endtask

  initial begin
    nrst = 1'b0; cs = 1'b0; bit_strobe = 1'b0; sdi = 1'b0;
    test_reset();
    test_single();
    test_short();
    test_overlong();
    test_back_to_back();
    test_reset_mid();
    test_edge_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial sample receiver for the delay core's converter link. It captures `WIDTH` bits from a serial data line during a chip-select frame and clocks them in on single-cycle bit strobes. It then presents the assembled word with a one-cycle valid pulse. The block sits on the receive side of the link whose frame window and bit strobes come from the core's chip-select and pulse-train generators. It feeds parallel ADC samples into the delay datapath.

## Interface
- `WIDTH`, 12, bits per frame / output word width
- `CNT_WIDTH`, 4, bit-counter width; must satisfy 2**CNT_WIDTH > WIDTH
- `clk`  in  1  system clock; all logic on rising edge
- `nrst`  in  1  reset, synchronous, active-low
- `cs`  in  1  frame window, active-high; frame = contiguous high interval
- `bit_strobe`  in  1  one-cycle sample strobe; `sdi` sampled on cycles where it is 1
- `sdi`  in  1  serial data, MSB first
- `data`  out  WIDTH  last complete received word, registered
- `valid`  out  1  one-cycle pulse, `data` updated this cycle
- `busy`  out  1  high while a frame is being shifted in
- `err`  out  1  one-cycle short-frame pulse (only with `SERIAL_RX_ERR_EN`)

## Operation
- States: IDLE, SHIFT, DONE, HOLD.
- IDLE:
  - A rising edge of `cs` goes to SHIFT on the next clock. Rising edge means `cs`=1 this cycle and `cs`=0 the previous cycle.
  - On that transition, clear the shift register and bit counter.
  - Strobes in the edge cycle are ignored.
- SHIFT:
  - On each cycle with `bit_strobe`=1 and `cs`=1, do `sr <= {sr[WIDTH-2:0], sdi}` and `cnt <= cnt+1`.
  - The strobe that brings `cnt` to WIDTH moves the block to DONE.
  - `cs`=0 before WIDTH bits → IDLE. No `valid`, `data` unchanged. `err` pulses if enabled.
  - A strobe coincident with `cs`=0 is not sampled.
- DONE (exactly one cycle):
  - `data <= sr`, `valid`=1.
  - Next state is HOLD if `cs`=1, else IDLE.
- HOLD: strobes ignored. `cs`=0 → IDLE.
- A new frame needs `cs` low for ≥1 cycle. `cs` held high across frames yields one word only.
- `busy` = (state == SHIFT).
- `data` holds its value between `valid` pulses and is never partially updated.

## Timing
- Reset values:
  - state IDLE
  - `data`=0, `valid`=0, `busy`=0, `err`=0
  - shift register 0, counter 0
- Reset mid-frame aborts silently: no `valid`, no `err`, `data` reset to 0.
- `cs` rising edge at cycle t → `busy`=1 at t+1.
- Last (WIDTH-th) strobe at cycle t → `valid`=1 and new `data` at t+1, `busy`=0 at t+1.
- Short frame: `cs` low at cycle t while in SHIFT → `busy`=0 and `err`=1 at t+1.
- Minimum strobe spacing is 1 cycle; consecutive-cycle strobes are all sampled.
- Counter never wraps: it stops at WIDTH, and extra strobes are dropped in HOLD.

## Configuration
- `SERIAL_RX_ERR_EN` defined:
  - `err` port exists.
  - `err` pulses for one cycle when a frame ends with 1..WIDTH-1 bits received.
  - A frame with 0 bits received also pulses `err`.
- Undefined:
  - `err` port absent; short frames are dropped silently.
  - All other behaviour is identical.

## Structure
- Shared package `delay_core_pkg`: rx state enum (`rx_state_t`: IDLE, SHIFT, DONE, HOLD) and constant `ADC_WIDTH`=12, used as the `WIDTH` default at instantiation.
- Sub-module: reuse the existing `edge_detector` for `cs` rising-edge detection (en tied high). Its output must be combinational on the registered previous `cs` so the edge cycle matches the definition above.
- The bit counter is the existing `counter` module (reset held while not in SHIFT) or an inline register.

## Test plan
- Single frame (WIDTH=12), strobes every 4 cycles, `sdi` = 0xA5C MSB first → `data`=0xA5C, `valid` high exactly 1 cycle, one cycle after the 12th strobe.
- Short frame: `cs` drops after 5 strobes → no `valid`, `data` keeps previous 0xA5C, `err`=1 for 1 cycle with the macro defined and no `err` port without it.
- Overlong frame: 14 strobes, first 12 bits 0x3F0 → `data`=0x3F0, exactly one `valid`, and strobes 13–14 ignored.
- Back-to-back frames 0x001 then 0xFFF separated by 1 low cycle of `cs` → two `valid` pulses with those values in order.
- Reset mid-frame after 6 bits → all outputs 0 next cycle. A following full frame of 0x123 → `data`=0x123.
- Strobe in the same cycle as the `cs` rising edge and in the same cycle as `cs` falling → neither sampled. 12 interior strobes → correct word.
